eeg_serial_deser: RTL

Receives the serial ADC result stream that the ear-EEG front-end chip shifts out under the control clocks generated by the prototype top, and rebuilds it into per-channel parallel samples. Frame start is `LOAD_G`; bit strobe is `fdata_G`. Samples are buffered in a small FIFO and presented on a valid/ready stream to the host-side packetiser. Sits directly downstream of the clock/previn generation stage, in the same `sys_clk` domain.

---
 rtl/eeg_deser_pkg.sv | 29 ++
 rtl/eeg_sync_fifo.sv | 81 ++++++++
 rtl/eeg_serial_deser.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_deser_pkg.sv
// eeg_deser_pkg: shared constants and types for the ear-EEG serial deserialiser.
//   DEF_DATA_W / DEF_NUM_CH / DEF_FIFO_DEPTH : default ADC word width, channels per frame, FIFO depth
//   CH_W           : channel index width
//   deser_state_t  : frame-capture FSM state
//   fifo_entry_t   : one buffered output word {data, ch, last[, frame]}
// Optional macro EEG_DESER_FRAMECNT_EN adds a 16-bit frame number to each entry.
package eeg_deser_pkg;

  localparam int DEF_DATA_W     = 10;
  localparam int DEF_NUM_CH     = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int CH_W           = $clog2(DEF_NUM_CH);
  localparam int FRAME_W        = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [CH_W-1:0]       ch;
    logic                  last;
`ifdef EEG_DESER_FRAMECNT_EN
    logic [FRAME_W-1:0]    frame;
`endif
  } fifo_entry_t;

endpackage

// File: rtl/eeg_sync_fifo.sv
// eeg_sync_fifo: single-clock FIFO with a registered head word.
//   sys_clk, rst_n : clock and synchronous active-low reset (flushes the FIFO)
//   wr_en, wr_data : push request; accepted when not full, or when full and popping
//   full           : DEPTH entries held (the head counts as an entry)
//   empty          : no word presented (registered)
//   rd_en          : pop the head when not empty
//   rd_data        : registered head word, stable until popped
module eeg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             valid_r;
  logic [WIDTH-1:0] head_r;

  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic [AW:0]      count_next_s;
  logic [AW-1:0]    rd_ptr_next_s;
  logic             drained_s;

  assign full_s        = (count_r == (AW+1)'(DEPTH));
  assign pop_s         = rd_en & valid_r;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push_s        = wr_en & (~full_s | pop_s);
  assign count_next_s  = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
  assign rd_ptr_next_s = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
  // Nothing left in memory after this pop: a simultaneous push must bypass to the head.
  assign drained_s     = (count_r == {{AW{1'b0}}, pop_s});

  // Storage array write port.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head word.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {(AW+1){1'b0}});
      if (push_s && drained_s) begin
        head_r <= wr_data;
      end else if (count_next_s != {(AW+1){1'b0}}) begin
        head_r <= mem_r[rd_ptr_next_s];
      end
    end
  end

  assign full    = full_s;
  assign empty   = ~valid_r;
  assign rd_data = head_r;

endmodule

// File: rtl/eeg_serial_deser.sv
// eeg_serial_deser: rebuilds the ear-EEG ADC serial stream into per-channel words.
//   sys_clk, rst_n     : clock and synchronous active-low reset
//   load_g             : frame start strobe (rising edge), asynchronous
//   fdata_g            : bit strobe (rising edge), asynchronous
//   sdata              : serial data, MSB first, asynchronous
//   m_valid/m_ready    : output stream handshake
//   m_data/m_ch/m_last : sample, channel index, last-channel marker
//   m_frame            : frame number (only with EEG_DESER_FRAMECNT_EN)
//   ovf_sticky         : a completed word was dropped on a full FIFO
//   frm_err_sticky     : a frame was cut short by a new load_g
//   err_clr            : clears both sticky flags (a same-cycle set wins)
// Optional macro: EEG_DESER_FRAMECNT_EN adds a 16-bit frame counter and m_frame.
module eeg_serial_deser
  import eeg_deser_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      load_g,
  input  logic                      fdata_g,
  input  logic                      sdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [$clog2(NUM_CH)-1:0] m_ch,
  output logic                      m_last,
`ifdef EEG_DESER_FRAMECNT_EN
  output logic [15:0]               m_frame,
`endif
  output logic                      ovf_sticky,
  output logic                      frm_err_sticky,
  input  logic                      err_clr
);

  localparam int BIT_W   = $clog2(DATA_W);
  localparam int CH_BITS = $clog2(NUM_CH);

  // Synchroniser bit order: {sdata, load_g, fdata_g}.
  logic [2:0]         meta_r;
  logic [2:0]         sync_r;
  logic [1:0]         prev_r;
  logic               load_rise_s;
  logic               bit_rise_s;
  logic               sdata_s;

  deser_state_t       state_r, state_n;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_n;
  logic [CH_BITS-1:0] ch_cnt_r, ch_cnt_n;
  logic [DATA_W-2:0]  sr_r, sr_n;
  logic [DATA_W-1:0]  sr_next_s;
  logic               last_ch_s;
  logic               word_done_s;
  logic               frm_err_s;
  logic               frame_start_s;

  fifo_entry_t        entry_s;
  fifo_entry_t        entry_r;
  logic               push_r;
  fifo_entry_t        head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               ovf_s;

`ifdef EEG_DESER_FRAMECNT_EN
  logic [15:0]        frame_cnt_r;
`endif

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      meta_r <= 3'b000;
      sync_r <= 3'b000;
      prev_r <= 2'b00;
    end else begin
      meta_r <= {sdata, load_g, fdata_g};
      sync_r <= meta_r;
      prev_r <= sync_r[1:0];
    end
  end

  assign load_rise_s = sync_r[1] & ~prev_r[1];
  assign bit_rise_s  = sync_r[0] & ~prev_r[0];
  assign sdata_s     = sync_r[2];
  assign sr_next_s   = {sr_r, sdata_s};
  assign last_ch_s   = (ch_cnt_r == CH_BITS'(NUM_CH - 1));

  // FSM and shift/count state registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BIT_W{1'b0}};
      ch_cnt_r  <= {CH_BITS{1'b0}};
      sr_r      <= {(DATA_W-1){1'b0}};
    end else begin
      state_r   <= state_n;
      bit_cnt_r <= bit_cnt_n;
      ch_cnt_r  <= ch_cnt_n;
      sr_r      <= sr_n;
    end
  end

  // Next-state logic; a load edge always takes priority over a coincident bit edge.
  always_comb begin
    state_n       = state_r;
    bit_cnt_n     = bit_cnt_r;
    ch_cnt_n      = ch_cnt_r;
    sr_n          = sr_r;
    word_done_s   = 1'b0;
    frm_err_s     = 1'b0;
    frame_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_rise_s) begin
          state_n       = SHIFT;
          bit_cnt_n     = {BIT_W{1'b0}};
          ch_cnt_n      = {CH_BITS{1'b0}};
          frame_start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (load_rise_s) begin
          frm_err_s     = (bit_cnt_r != {BIT_W{1'b0}}) || (ch_cnt_r != {CH_BITS{1'b0}});
          bit_cnt_n     = {BIT_W{1'b0}};
          ch_cnt_n      = {CH_BITS{1'b0}};
          frame_start_s = 1'b1;
        end else if (bit_rise_s) begin
          sr_n = sr_next_s[DATA_W-2:0];
          if (bit_cnt_r == BIT_W'(DATA_W - 1)) begin
            word_done_s = 1'b1;
            bit_cnt_n   = {BIT_W{1'b0}};
            if (last_ch_s) begin
              ch_cnt_n = {CH_BITS{1'b0}};
              state_n  = IDLE;
            end else begin
              ch_cnt_n = ch_cnt_r + CH_BITS'(1);
            end
          end else begin
            bit_cnt_n = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          state_n = SHIFT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Assemble the FIFO entry for a word completing this cycle.
  always_comb begin
    entry_s.data  = sr_next_s;
    entry_s.ch    = ch_cnt_r;
    entry_s.last  = last_ch_s;
`ifdef EEG_DESER_FRAMECNT_EN
    entry_s.frame = frame_cnt_r;
`endif
  end

  // Registered push stage feeding the FIFO.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      push_r  <= 1'b0;
      entry_r <= fifo_entry_t'(0);
    end else begin
      push_r  <= word_done_s;
      entry_r <= entry_s;
    end
  end

`ifdef EEG_DESER_FRAMECNT_EN
  // Frame counter: counts every load edge that enters or restarts capture.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'h0000;
    end else if (frame_start_s) begin
      frame_cnt_r <= frame_cnt_r + 16'h0001;
    end
  end
`endif

  eeg_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (push_r),
    .wr_data (entry_r),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .rd_en   (m_ready),
    .rd_data (head_s)
  );

  // Dropped exactly when the FIFO refuses the push (full with no pop this cycle).
  assign ovf_s = push_r & fifo_full_s & ~(m_valid & m_ready);

  // Sticky error flags; a new error wins over a clear in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      ovf_sticky     <= 1'b0;
      frm_err_sticky <= 1'b0;
    end else begin
      if (ovf_s) begin
        ovf_sticky <= 1'b1;
      end else if (err_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (frm_err_s) begin
        frm_err_sticky <= 1'b1;
      end else if (err_clr) begin
        frm_err_sticky <= 1'b0;
      end
    end
  end

  assign m_valid = ~fifo_empty_s;
  assign m_data  = head_s.data;
  assign m_ch    = head_s.ch;
  assign m_last  = head_s.last;
`ifdef EEG_DESER_FRAMECNT_EN
  assign m_frame = head_s.frame;
`endif

endmodule
